// File: rtl/store_unit.sv
// Store unit: lane-aligns SB/SH/SW/SD stores into memory write beats.
// Define STORE_UNIT_MISALIGN_SPLIT_EN to split word-crossing stores into two beats.
module store_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              done,
  output logic              err
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int MW = 2 * NB;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   wdata_q;

  logic [OW-1:0]     off;
  logic [MW-1:0]     ones;
  logic [ADDR_W-1:0] base;
  logic [NB-1:0]     m_lo;
  logic [XLEN-1:0]   d_lo;
  logic              req_bad;
  logic              resp_bad;

  function automatic logic bad_size(input logic [2:0] f);
    return f[2] || (XLEN == 32 && f[1:0] == 2'b11);
  endfunction

  function automatic logic [XLEN-1:0] lanes(
    input logic [XLEN-1:0] d,
    input logic [NB-1:0]   be
  );
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++)
      r[8*i +: 8] = be[i] ? d[8*i +: 8] : 8'h00;
    return r;
  endfunction

  assign off  = addr_q[OW-1:0];
  assign base = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};

  always_comb begin
    ones = '0;
    unique case (1'b1)
      f3_q[1:0] == 2'b00: ones = MW'(1);
      f3_q[1:0] == 2'b01: ones = MW'(3);
      f3_q[1:0] == 2'b10: ones = MW'(15);
      f3_q[1:0] == 2'b11: ones = MW'(255);
    endcase
  end

`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
  logic [MW-1:0]     m_full;
  logic [2*XLEN-1:0] d_full;
  logic [NB-1:0]     m_hi;
  logic [XLEN-1:0]   d_hi;

  assign m_full   = ones << off;
  assign d_full   = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
  assign m_lo     = m_full[NB-1:0];
  assign m_hi     = m_full[MW-1:NB];
  assign d_lo     = d_full[XLEN-1:0];
  assign d_hi     = d_full[2*XLEN-1:XLEN];
  assign req_bad  = bad_size(funct3);
  assign resp_bad = bad_size(f3_q);
`else
  function automatic logic misal(
    input logic [1:0]    sz,
    input logic [OW-1:0] o
  );
    logic [OW-1:0] am;
    unique case (sz)
      2'b00:   am = '0;
      2'b01:   am = OW'(1);
      2'b10:   am = OW'(3);
      default: am = OW'(7);
    endcase
    return (o & am) != '0;
  endfunction

  assign m_lo     = NB'(ones << off);
  assign d_lo     = wdata_q << {off, 3'b000};
  assign req_bad  = bad_size(funct3) || misal(funct3[1:0], addr[OW-1:0]);
  assign resp_bad = bad_size(f3_q) || misal(f3_q[1:0], off);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_valid && req_ready) begin
        addr_q  <= addr;
        f3_q    <= funct3;
        wdata_q <= wdata;
      end
    end
  end

  // Beat outputs come only from captured state, so they hold while stalled.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_d = req_bad ? RESP : BEAT0;
      end
      BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = base;
        mem_be    = m_lo;
        mem_wdata = lanes(d_lo, m_lo);
        if (mem_ready) begin
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
          state_d = (|m_hi) ? BEAT1 : RESP;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
      BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = base + ADDR_W'(NB);
        mem_be    = m_hi;
        mem_wdata = lanes(d_hi, m_hi);
        if (mem_ready)
          state_d = RESP;
      end
`endif
      RESP: begin
        done    = ~resp_bad;
        err     = resp_bad;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit at XLEN=32.
// Split-beat vectors follow STORE_UNIT_MISALIGN_SPLIT_EN.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        done;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  store_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d);
    funct3    = f;
    addr      = a;
    wdata     = d;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    check({tag, ".valid"}, 64'(mem_valid), 64'd1);
    check({tag, ".addr"},  64'(mem_addr),  64'(a));
    check({tag, ".be"},    64'(mem_be),    64'(be));
    check({tag, ".data"},  64'(mem_wdata), 64'(d));
  endtask

  task automatic resp(input string tag, input logic d, input logic e);
    check({tag, ".done"},  64'(done),      64'(d));
    check({tag, ".err"},   64'(err),       64'(e));
    check({tag, ".mvld"},  64'(mem_valid), 64'd0);
  endtask

  logic [2:0] bad_f3 [3] = '{3'b011, 3'b100, 3'b110};
  logic       seen;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    funct3    = '0;
    addr      = '0;
    wdata     = '0;
    mem_ready = 1'b1;
    #12;
    check("rst.ready", 64'(req_ready), 64'd1);
    check("rst.mvld",  64'(mem_valid), 64'd0);
    check("rst.done",  64'(done),      64'd0);
    check("rst.err",   64'(err),       64'd0);
    check("rst.addr",  64'(mem_addr),  64'd0);
    check("rst.be",    64'(mem_be),    64'd0);
    check("rst.data",  64'(mem_wdata), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    issue(3'b000, 32'h1003, 32'h0000_00AB);
    beat("sb", 32'h1000, 4'b1000, 32'hAB00_0000);
    step();
    resp("sb", 1'b1, 1'b0);
    step();
    check("sb.idle_done", 64'(done), 64'd0);
    check("sb.ready", 64'(req_ready), 64'd1);

    mem_ready = 1'b0;
    issue(3'b001, 32'h1002, 32'h0000_1234);
    for (int k = 0; k < 4; k++) begin
      beat($sformatf("sh%0d", k), 32'h1000, 4'b1100, 32'h1234_0000);
      check("sh.busy", 64'(req_ready), 64'd0);
      if (k == 3) mem_ready = 1'b1;
      step();
    end
    resp("sh", 1'b1, 1'b0);
    step();

    issue(3'b000, 32'h1001, 32'hFFFF_FF5A);
    beat("sbz", 32'h1000, 4'b0010, 32'h0000_5A00);
    step();
    resp("sbz", 1'b1, 1'b0);
    step();

    issue(3'b010, 32'h2000, 32'hDEAD_BEEF);
    beat("sw", 32'h2000, 4'b1111, 32'hDEAD_BEEF);
    step();
    resp("sw", 1'b1, 1'b0);
    step();

    issue(3'b010, 32'h1003, 32'h1122_3344);
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
    beat("swm0", 32'h1000, 4'b1000, 32'h4400_0000);
    step();
    beat("swm1", 32'h1004, 4'b0111, 32'h0011_2233);
    step();
    resp("swm", 1'b1, 1'b0);
`else
    resp("swm", 1'b0, 1'b1);
`endif
    step();
    check("swm.clr", 64'(err | done), 64'd0);

    for (int i = 0; i < 3; i++) begin
      issue(bad_f3[i], 32'h4000, 32'h5555_5555);
      resp($sformatf("ill%0d", i), 1'b0, 1'b1);
      step();
      check("ill.clr", 64'(err), 64'd0);
    end

    mem_ready = 1'b0;
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
    issue(3'b010, 32'h1003, 32'h1122_3344);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("mid.b1", 64'(mem_addr), 64'h1004);
`else
    issue(3'b010, 32'h3000, 32'h1122_3344);
    check("mid.b0", 64'(mem_valid), 64'd1);
`endif
    rst_n = 1'b0;
    #1;
    check("mid.mvld",  64'(mem_valid), 64'd0);
    check("mid.ready", 64'(req_ready), 64'd1);
    check("mid.be",    64'(mem_be),    64'd0);
    mem_ready = 1'b1;
    seen = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      seen = seen | done | err | mem_valid;
      step();
    end
    check("mid.quiet", 64'(seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
